// File: rtl/cordic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_seq_ctrl
//
// Sequencer for an iterative CORDIC datapath.  Accepts a target angle with a
// valid/ready handshake, issues one LOAD cycle so the x/y/angle registers take
// their initial values, then steps the datapath through N_ITER iterations by
// enabling the registers and presenting the iteration index.  The final
// result is announced with a valid/ready handshake; the registers are frozen
// (reg_en low) while the result is pending.
//
// Optional feature (compile-time macro):
//   CORDIC_SEQ_CTRL_EARLY_EXIT_EN - when defined, a zero residual angle in an
//   iteration cycle ends the operation early (that cycle does not update the
//   registers and is not counted).  When undefined, res_angle is ignored and
//   every operation runs exactly N_ITER iterations.
//
// Parameters:
//   W       angle datapath width
//   N_ITER  iterations per operation, 1..16
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   start_valid       request to begin an operation
//   start_ready       controller is idle and can accept a start
//   target_angle      requested angle, captured on the start handshake
//   abort             synchronous cancel of the operation in progress
//   res_angle         residual angle from the pipeline angle register
//   reg_en            enable for the x/y/angle pipeline registers
//   load              registers take initial values instead of iteration data
//   iter_idx          current iteration index (register select)
//   target_angle_out  captured target angle, stable for the whole operation
//   done_valid        register contents are the final result
//   done_ready        consumer has taken the result
//   iters_done        iterations actually performed, valid with done_valid
//   busy              any state other than IDLE
// -----------------------------------------------------------------------------
module cordic_seq_ctrl #(
  parameter int W      = 24,
  parameter int N_ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] target_angle,
  input  logic         abort,
  input  logic [W-1:0] res_angle,
  output logic         reg_en,
  output logic         load,
  output logic [3:0]   iter_idx,
  output logic [W-1:0] target_angle_out,
  output logic         done_valid,
  input  logic         done_ready,
  output logic [4:0]   iters_done,
  output logic         busy
);

  if (N_ITER < 1 || N_ITER > 16) begin : g_bad_n_iter
    $error("cordic_seq_ctrl: N_ITER must be in 1..16");
  end

  localparam logic [3:0] LAST_IDX = 4'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     iter_q, iter_d;
  logic [4:0]     iters_q, iters_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           reg_en_c;
  logic           load_c;
  logic           early_exit;

  // ---------------------------------------------------------------------------
  // Early-exit detection
  // ---------------------------------------------------------------------------
`ifdef CORDIC_SEQ_CTRL_EARLY_EXIT_EN
  assign early_exit = (res_angle == '0);
`else
  // Port kept for a uniform interface; the residual is deliberately unused.
  logic unused_res_angle;
  assign unused_res_angle = ^res_angle;
  assign early_exit       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      iters_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      iters_q <= iters_d;
      tgt_q   <= tgt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    iters_d  = iters_q;
    tgt_d    = tgt_q;
    reg_en_c = 1'b0;
    load_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here and must not block a start.
        if (start_valid) begin
          tgt_d   = target_angle;
          iter_d  = '0;
          iters_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          reg_en_c = 1'b1;
          load_c   = 1'b1;
          state_d  = S_ITER;
        end
      end

      S_ITER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (early_exit) begin
          // Residual already zero: freeze registers, this cycle not counted.
          state_d = S_DONE;
        end else begin
          reg_en_c = 1'b1;
          iters_d  = iters_q + 5'd1;
          // The index stops at the last value instead of wrapping; it is held
          // through DONE so the consumer sees the final select.
          if (iter_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            iter_d = iter_q + 4'd1;
          end
        end
      end

      S_DONE: begin
        if (abort || done_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign reg_en           = reg_en_c;
  assign load             = load_c;
  assign iter_idx         = iter_q;
  assign iters_done       = iters_q;
  assign target_angle_out = tgt_q;
  assign done_valid       = (state_q == S_DONE);
  assign start_ready      = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_load_en : assert property (@(posedge clk) disable iff (!rst_n)
    load |-> reg_en);
  a_done_frozen : assert property (@(posedge clk) disable iff (!rst_n)
    done_valid |-> !reg_en);
  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n)
    iter_idx <= LAST_IDX);
  a_ready_idle : assert property (@(posedge clk) disable iff (!rst_n)
    start_ready == !busy);

endmodule
